// File: rtl/bin2decdigi_seq.sv
// rtl/bin2decdigi_seq.sv - iterative double-dabble binary to multi-digit 7-segment converter
// Shifts one bit per cycle, then registers blanked/overflow-aware segment codes on DONE entry.
module bin2decdigi_seq #(
  parameter int BIN_W    = 10,
  parameter int N_DIGITS = 3,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7*N_DIGITS-1:0] digi,
  output logic                  ovf
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) p = p * 32'd10;
    return p;
  endfunction

  localparam logic [31:0] LIMIT = pow10(N_DIGITS);

  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    case (nib)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0011000;
      4'd2:    return 7'b1110110;
      4'd3:    return 7'b1111100;
      4'd4:    return 7'b1011001;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1101111;
      4'd7:    return 7'b0111000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111101;
      default: return SEG_BLANK;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [BIN_W-1:0]        shift_q;
  logic [BCD_W-1:0]        bcd_q;
  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W-1:0]        bcd_next;
  logic [BIN_W-1:0]        shift_next;
  logic [CNT_W-1:0]        count_q;
  logic                    ovf_n_q;
  logic [7*N_DIGITS-1:0]   digi_next;
  logic                    accept;
  logic                    last_shift;
  logic                    seen;
  logic [3:0]              nib;
  logic [31:0]             bin_ext;

  assign bin_ext    = 32'(bin);
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign accept     = in_valid && in_ready;
  assign last_shift = (state_q == SHIFT) && (count_q == CNT_W'(1));

  // Double-dabble correction: any nibble >=5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  assign bcd_next   = {bcd_adj[BCD_W-2:0], shift_q[BIN_W-1]};
  assign shift_next = shift_q << 1;

  // Decode from the post-shift BCD so the result is ready on the DONE-entry edge.
  always_comb begin
    digi_next = '0;
    seen      = 1'b0;
    nib       = 4'd0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      nib = bcd_next[4*k +: 4];
      if (nib != 4'd0) seen = 1'b1;
      if (ovf_n_q || (BLANK_LZ && (k > 0) && !seen)) digi_next[7*k +: 7] = SEG_BLANK;
      else digi_next[7*k +: 7] = seg_of(nib);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      count_q <= '0;
      ovf_n_q <= 1'b0;
      digi    <= '0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        shift_q <= bin;
        bcd_q   <= '0;
        count_q <= CNT_W'(BIN_W);
        ovf_n_q <= (bin_ext >= LIMIT);
      end else if (state_q == SHIFT) begin
        shift_q <= shift_next;
        bcd_q   <= bcd_next;
        count_q <= count_q - CNT_W'(1);
        if (last_shift) begin
          digi <= digi_next;
          ovf  <= ovf_n_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin2decdigi_seq.sv
// tb/tb_bin2decdigi_seq.sv - self-checking bench for bin2decdigi_seq
// Two instances share stimulus: one with leading-zero blanking, one without.
module tb_bin2decdigi_seq;

  localparam int W = 10;
  localparam int N = 3;

  logic           clock = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   bin = '0;
  logic           in_ready, out_valid, ovf;
  logic           in_ready0, out_valid0, ovf0;
  logic [7*N-1:0] digi, digi0;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0011000, 7'b1110110, 7'b1111100, 7'b1011001,
                               7'b1101101, 7'b1101111, 7'b0111000, 7'b1111111, 7'b1111101};

  always #5 clock = ~clock;

  bin2decdigi_seq #(.BIN_W(W), .N_DIGITS(N), .BLANK_LZ(1'b1)) dut (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready), .digi(digi), .ovf(ovf)
  );

  bin2decdigi_seq #(.BIN_W(W), .N_DIGITS(N), .BLANK_LZ(1'b0)) dut_nz (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .bin(bin),
    .out_valid(out_valid0), .out_ready(out_ready), .digi(digi0), .ovf(ovf0)
  );

  // Reference: decimal digits by division; a digit above 0 is blank when the value is below its weight.
  function automatic logic [7*N-1:0] ref_digi(input int v, input bit lz);
    logic [7*N-1:0] r;
    int p;
    r = '0;
    if (v >= 1000) return r;
    p = 1;
    for (int k = 0; k < N; k++) begin
      if (k == 0 || !lz || v >= p) r[7*k +: 7] = seg_tab[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  task automatic send(input int v, output int lat);
    @(negedge clock);
    in_valid = 1'b1;
    bin = W'(v);
    @(negedge clock);
    in_valid = 1'b0;
    bin = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic ack;
    @(negedge clock);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({in_ready, out_valid, ovf, digi} !== {1'b1, 1'b0, 1'b0, 21'd0})
      $display("FAIL reset_state: got rdy=%b vld=%b ovf=%b digi=%h, need 1 0 0 000000",
               in_ready, out_valid, ovf, digi);
    if ({in_ready, out_valid, ovf, digi} !== {1'b1, 1'b0, 1'b0, 21'd0}) errors++;
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  task automatic test_zero;
    int lat;
    send(0, lat);
    checks++;
    if (lat !== W + 1) begin
      errors++;
      $display("FAIL zero_latency: got %0d edges, need %0d", lat, W + 1);
    end
    checks++;
    if (digi !== {7'b0, 7'b0, 7'b0111111} || ovf !== 1'b0) begin
      errors++;
      $display("FAIL zero_value: got digi=%b ovf=%b, need %b 0", digi, ovf, {7'b0, 7'b0, 7'b0111111});
    end
    ack();
  endtask

  task automatic test_limits;
    int lat;
    int vals [3] = '{999, 1000, 1023};
    for (int i = 0; i < 3; i++) begin
      send(vals[i], lat);
      checks++;
      if (out_valid !== 1'b1 || digi !== ref_digi(vals[i], 1'b1) || ovf !== (vals[i] >= 1000)) begin
        errors++;
        $display("FAIL limit_%0d: got vld=%b digi=%b ovf=%b, need 1 %b %b", vals[i], out_valid, digi, ovf,
                 ref_digi(vals[i], 1'b1), vals[i] >= 1000);
      end
      ack();
    end
  endtask

  task automatic test_lz;
    int lat;
    send(7, lat);
    checks++;
    if (digi !== {7'b0, 7'b0, 7'b0111000}) begin
      errors++;
      $display("FAIL lz_on: got %b, need %b", digi, {7'b0, 7'b0, 7'b0111000});
    end
    checks++;
    if (digi0 !== {7'b0111111, 7'b0111111, 7'b0111000} || ovf0 !== 1'b0) begin
      errors++;
      $display("FAIL lz_off: got %b ovf=%b, need %b 0", digi0, ovf0, {7'b0111111, 7'b0111111, 7'b0111000});
    end
    ack();
  endtask

  task automatic test_hold;
    int lat;
    logic [7*N-1:0] held;
    send(456, lat);
    held = ref_digi(456, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      bin = W'($urandom);
      checks++;
      if ({out_valid, in_ready, digi} !== {1'b1, 1'b0, held}) begin
        errors++;
        $display("FAIL hold_cycle%0d: got vld=%b rdy=%b digi=%b, need 1 0 %b", i, out_valid, in_ready, digi, held);
      end
    end
    in_valid = 1'b0;
    ack();
    checks++;
    if ({out_valid, in_ready, digi} !== {1'b0, 1'b1, held}) begin
      errors++;
      $display("FAIL hold_release: got vld=%b rdy=%b digi=%b, need 0 1 %b", out_valid, in_ready, digi, held);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    @(negedge clock);
    in_valid = 1'b1;
    bin = W'(77);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, ovf, digi} !== {1'b1, 1'b0, 1'b0, 21'd0}) begin
      errors++;
      $display("FAIL reset_mid: got rdy=%b vld=%b ovf=%b digi=%h, need 1 0 0 000000", in_ready, out_valid, ovf, digi);
    end
    @(negedge clock);
    rst_n = 1'b1;
    repeat (15) @(negedge clock);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_abort: got vld=%b rdy=%b, need 0 1", out_valid, in_ready);
    end
    send(305, lat);
    checks++;
    if (digi !== {7'b1111100, 7'b0111111, 7'b1101101} || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_305: got %b vld=%b, need %b 1", digi, out_valid, {7'b1111100, 7'b0111111, 7'b1101101});
    end
    ack();
  endtask

  task automatic test_random;
    int lat;
    int v;
    for (int i = 0; i < 25; i++) begin
      v = int'($urandom_range(0, 1023));
      send(v, lat);
      checks++;
      if (lat !== W + 1 || digi !== ref_digi(v, 1'b1) || digi0 !== ref_digi(v, 1'b0)
          || ovf !== (v >= 1000) || ovf0 !== (v >= 1000)) begin
        errors++;
        $display("FAIL random_%0d: got lat=%0d digi=%b digi0=%b ovf=%b, need lat=%0d %b %b %b", v, lat, digi, digi0,
                 ovf, W + 1, ref_digi(v, 1'b1), ref_digi(v, 1'b0), v >= 1000);
      end
      ack();
    end
  endtask

  task automatic test_back_to_back;
    int q[$];
    int sent = 0, got = 0, cyc = 0, last = -1, exp_v;
    @(negedge clock);
    out_ready = 1'b1;
    while (got < 1024 && cyc < 1024 * (W + 2) + 200) begin
      if (out_valid) begin
        exp_v = (q.size() > 0) ? q.pop_front() : -1;
        checks++;
        if (exp_v < 0 || digi !== ref_digi(exp_v, 1'b1) || digi0 !== ref_digi(exp_v, 1'b0) || ovf !== (exp_v >= 1000)) begin
          errors++;
          $display("FAIL b2b_value_%0d: got digi=%b digi0=%b ovf=%b", exp_v, digi, digi0, ovf);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != W + 2) begin
            errors++;
            $display("FAIL b2b_period: got %0d cycles, need %0d", cyc - last, W + 2);
          end
        end
        last = cyc;
        got++;
      end
      if (in_ready && sent < 1024) begin
        in_valid = 1'b1;
        bin = W'(sent);
        q.push_back(sent);
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got != 1024) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, need 1024", got);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_limits();
    test_lz();
    test_hold();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
